wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: num_m masters share one register-file slave,
// with grant locking for the whole bus cycle and a slave-ack timeout.
//
// state    | meaning
// IDLE     | no owner; picks next requester in round-robin order
// BUSY     | granted master routed to slave; wait counter running
// ERR_HOLD | timed out; slave side quiet until owner drops cyc
module wb_arbiter #(
  parameter int num_m      = 2,
  parameter int adr_width  = 16,
  parameter int mem_width  = 16,
  parameter int tmo_cycles = 15
) (
  input  logic                         i_wb_clk,
  input  logic                         i_wb_rst,
  input  logic [num_m-1:0]             i_m_cyc,
  input  logic [num_m-1:0]             i_m_stb,
  input  logic [num_m-1:0]             i_m_we,
  input  logic [num_m*adr_width-1:0]   i_m_adr,
  input  logic [num_m*mem_width-1:0]   i_m_data,
  output logic [num_m-1:0]             o_m_ack,
  output logic [num_m-1:0]             o_m_err,
  output logic [mem_width-1:0]         o_m_data,
  output logic [num_m-1:0]             o_grant,
  output logic                         o_s_cyc,
  output logic                         o_s_stb,
  output logic                         o_s_we,
  output logic [adr_width-1:0]         o_s_adr,
  output logic [mem_width-1:0]         o_s_data,
  input  logic                         i_s_ack,
  input  logic [mem_width-1:0]         i_s_data
);

  localparam int IW = (num_m > 1) ? $clog2(num_m) : 1;
  localparam int CW = ($clog2(tmo_cycles + 1) > 4) ? $clog2(tmo_cycles + 1) : 4;

  typedef enum logic [1:0] {IDLE, BUSY, ERR_HOLD} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic [IW-1:0]   cand;
  logic            timeout;

  logic                 g_cyc, g_stb, g_we;
  logic [adr_width-1:0] g_adr;
  logic [mem_width-1:0] g_data;

  // last_q doubles as the current owner index once a grant is made
  assign g_cyc  = i_m_cyc[last_q];
  assign g_stb  = i_m_stb[last_q];
  assign g_we   = i_m_we[last_q];
  assign g_adr  = i_m_adr[int'(last_q) * adr_width +: adr_width];
  assign g_data = i_m_data[int'(last_q) * mem_width +: mem_width];

  assign o_m_data = i_s_data;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    wait_d   = '0;
    cand     = '0;
    timeout  = 1'b0;
    o_grant  = '0;
    o_m_ack  = '0;
    o_m_err  = '0;
    o_s_cyc  = 1'b0;
    o_s_stb  = 1'b0;
    o_s_we   = 1'b0;
    o_s_adr  = '0;
    o_s_data = '0;

    unique case (state_q)
      IDLE: begin
        if (|i_m_cyc) begin
          // scan farthest-first so the nearest requester after last_q wins
          for (int i = num_m; i >= 1; i--) begin
            cand = IW'((int'(last_q) + i) % num_m);
            if (i_m_cyc[cand]) last_d = cand;
          end
          state_d = BUSY;
        end
      end
      BUSY: begin
        o_grant[last_q] = 1'b1;
        o_s_cyc  = g_cyc;
        o_s_stb  = g_stb;
        o_s_we   = g_we;
        o_s_adr  = g_adr;
        o_s_data = g_data;
        o_m_ack[last_q] = i_s_ack;
        // an ack on the threshold cycle suppresses the error
        timeout = g_cyc && g_stb && !i_s_ack && (wait_q == CW'(tmo_cycles));
        o_m_err[last_q] = timeout;
        if (!g_cyc)
          state_d = IDLE;
        else if (timeout)
          state_d = ERR_HOLD;
        else if (g_stb && !i_s_ack)
          wait_d = wait_q + CW'(1);
      end
      ERR_HOLD: begin
        o_grant[last_q] = 1'b1;
        if (!g_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state_q <= IDLE;
      last_q  <= IW'(num_m - 1);
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
    end
  end

endmodule
